// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-requester RAM arbiter:
// FSM encodings, default widths, requester indices and a one-hot helper.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam int AW_DEF = 6;
  localparam int DW_DEF = 16;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic logic [1:0] onehot2(input logic idx);
    onehot2 = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side command/response bundle shared by both masters and the arbiter.
// The arbiter is the slave; the masters (or a bench) drive the master side.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic [1:0]    req_valid;
  logic [1:0]    req_write;
  logic [AW-1:0] req_addr0;
  logic [AW-1:0] req_addr1;
  logic [DW-1:0] req_wdata0;
  logic [DW-1:0] req_wdata1;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// on a tie the requester that was not granted last time wins.
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       winner
);

  always_comb begin
    winner = REQ0;
    grant  = 2'b00;
    case (valid)
      2'b01: begin
        winner = REQ0;
        grant  = 2'b01;
      end
      2'b10: begin
        winner = REQ1;
        grant  = 2'b10;
      end
      2'b11: begin
        winner = ~last_grant;
        grant  = onehot2(~last_grant);
      end
      default: begin
        winner = REQ0;
        grant  = 2'b00;
      end
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer for a single-port RAM with combinational read.
// Clears the whole array after reset or on request, then serves one access per two cycles.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear_start,
  output logic          init_done,
  ram_arbiter_if.slave  bus,
  output logic [DW-1:0] ram_in,
  output logic          ram_load,
  output logic [AW-1:0] ram_address,
  input  logic [DW-1:0] ram_out
);

  localparam logic [AW-1:0] CNT_MAX = {AW{1'b1}};
  localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_r;
  state_t        state_nxt_s;
  logic [AW-1:0] clr_cnt_r;
  logic          last_grant_r;
  logic          init_done_r;
  logic [1:0]    rsp_valid_r;
  logic [DW-1:0] rsp_rdata_r;
  logic          cmd_write_r;
  logic [AW-1:0] cmd_addr_r;
  logic [DW-1:0] cmd_wdata_r;
  logic          cmd_id_r;

  logic [1:0]    pick_grant_s;
  logic          pick_winner_s;
  logic [1:0]    ready_s;

  rr_pick2 u_pick (
    .valid      (bus.req_valid),
    .last_grant (last_grant_r),
    .grant      (pick_grant_s),
    .winner     (pick_winner_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (clr_cnt_r == CNT_MAX) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (clear_start) begin
          state_nxt_s = ST_INIT;
        end else if (|bus.req_valid) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_INIT;
    endcase
  end

  // RAM strobes and grants are masked while reset is held, whatever the state.
  always_comb begin
    ram_address = {AW{1'b0}};
    ram_in      = {DW{1'b0}};
    ram_load    = 1'b0;
    ready_s     = 2'b00;
    case (state_r)
      ST_INIT: begin
        ram_address = clr_cnt_r;
        ram_in      = {DW{1'b0}};
        ram_load    = ~reset;
      end
      ST_IDLE: begin
        if (!reset && !clear_start) begin
          ready_s = pick_grant_s;
        end else begin
          ready_s = 2'b00;
        end
      end
      ST_ACCESS: begin
        ram_address = cmd_addr_r;
        ram_in      = cmd_wdata_r;
        ram_load    = cmd_write_r & ~reset;
      end
      default: begin
        ram_load = 1'b0;
        ready_s  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clr_cnt_r    <= {AW{1'b0}};
      last_grant_r <= REQ1;
      init_done_r  <= 1'b0;
      rsp_valid_r  <= 2'b00;
      rsp_rdata_r  <= {DW{1'b0}};
      cmd_write_r  <= 1'b0;
      cmd_addr_r   <= {AW{1'b0}};
      cmd_wdata_r  <= {DW{1'b0}};
      cmd_id_r     <= REQ0;
    end else begin
      rsp_valid_r <= 2'b00;
      case (state_r)
        ST_INIT: begin
          clr_cnt_r   <= clr_cnt_r + CNT_ONE;
          init_done_r <= (clr_cnt_r == CNT_MAX);
        end
        ST_IDLE: begin
          if (clear_start) begin
            clr_cnt_r   <= {AW{1'b0}};
            init_done_r <= 1'b0;
          end else if (|bus.req_valid) begin
            cmd_write_r  <= bus.req_write[pick_winner_s];
            cmd_addr_r   <= pick_winner_s ? bus.req_addr1 : bus.req_addr0;
            cmd_wdata_r  <= pick_winner_s ? bus.req_wdata1 : bus.req_wdata0;
            cmd_id_r     <= pick_winner_s;
            last_grant_r <= pick_winner_s;
          end
        end
        ST_ACCESS: begin
          rsp_rdata_r <= cmd_write_r ? cmd_wdata_r : ram_out;
          rsp_valid_r <= onehot2(cmd_id_r);
        end
        default: begin
          rsp_valid_r <= 2'b00;
        end
      endcase
    end
  end

  assign init_done     = init_done_r;
  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 64x16 RAM that fills
// with 0xDEAD while reset is high, so the clear sequence is observable.
module tb_ram_arbiter;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clear_start = 1'b0;
  logic          init_done;
  logic [DW-1:0] ram_in;
  logic          ram_load;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_out;

  ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .clear_start (clear_start),
    .init_done   (init_done),
    .bus         (bus),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_address (ram_address),
    .ram_out     (ram_out)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [DEPTH];

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'hDEAD;
    end else if (ram_load) begin
      mem[ram_address] <= ram_in;
    end
  end

  assign ram_out = mem[ram_address];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expects the block to be in INIT with clr_cnt=0 on entry; leaves it in IDLE.
  task automatic clear_check();
    logic [AW-1:0] a;
    logic [24:0]   exp_bus;
    for (int i = 0; i < DEPTH; i++) begin
      a       = AW'(i);
      exp_bus = {1'b1, a, 16'h0000, 2'b00};
      check("clear_bus", {7'd0, ram_load, ram_address, ram_in, bus.req_ready}, {7'd0, exp_bus});
      check("clear_done_low", {31'd0, init_done}, 32'd0);
      tick();
    end
    check("clear_done_rise", {31'd0, init_done}, 32'd1);
    check("clear_load_off", {31'd0, ram_load}, 32'd0);
  endtask

  logic [1:0] exp_g;
  logic [1:0] prev_g;
  logic [5:0] exp_a;

  initial begin
    bus.req_valid  = 2'b00;
    bus.req_write  = 2'b00;
    bus.req_addr0  = 6'd0;
    bus.req_addr1  = 6'd0;
    bus.req_wdata0 = 16'h0000;
    bus.req_wdata1 = 16'h0000;

    // Reset state, with both requesters clamouring
    bus.req_valid = 2'b11;
    tick();
    tick();
    check("rst_load", {31'd0, ram_load}, 32'd0);
    check("rst_ready", {30'd0, bus.req_ready}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
    bus.req_valid = 2'b00;
    reset = 1'b0;
    #1;
    clear_check();

    // Continuous tie: 01,10,01,10 with requester 0 first
    bus.req_valid = 2'b11;
    bus.req_write = 2'b00;
    bus.req_addr0 = 6'd1;
    bus.req_addr1 = 6'd2;
    prev_g = 2'b00;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (k % 2 == 0) ? 6'd1 : 6'd2;
      check("tie_grant", {30'd0, bus.req_ready}, {30'd0, exp_g});
      check("tie_rsp_prev", {30'd0, bus.rsp_valid}, {30'd0, prev_g});
      tick();
      check("tie_access", {23'd0, ram_load, ram_address, bus.req_ready}, {23'd0, 1'b0, exp_a, 2'b00});
      tick();
      check("tie_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
      prev_g = exp_g;
    end
    bus.req_valid = 2'b00;
    #1;
    check("tie_rsp_last", {30'd0, bus.rsp_valid}, 32'd2);
    check("tie_ready_off", {30'd0, bus.req_ready}, 32'd0);

    // Requester 0: write 0x1234 to 5, then read it back
    bus.req_valid  = 2'b01;
    bus.req_write  = 2'b01;
    bus.req_addr0  = 6'd5;
    bus.req_wdata0 = 16'h1234;
    #1;
    check("wr_ready", {30'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 2'b00;
    #1;
    check("wr_access", {7'd0, ram_load, ram_address, ram_in, bus.req_ready}, {7'd0, 1'b1, 6'd5, 16'h1234, 2'b00});
    tick();
    check("wr_ack_valid", {30'd0, bus.rsp_valid}, 32'd1);
    check("wr_ack_data", {16'd0, bus.rsp_rdata}, 32'h1234);
    bus.req_valid = 2'b01;
    bus.req_write = 2'b00;
    #1;
    check("rd_ready", {30'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 2'b00;
    #1;
    check("rd_access", {23'd0, ram_load, ram_address, bus.rsp_valid}, {23'd0, 1'b0, 6'd5, 2'b00});
    tick();
    check("rd_rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
    check("rd_rsp_data", {16'd0, bus.rsp_rdata}, 32'h1234);
    tick();
    check("rd_rsp_pulse", {30'd0, bus.rsp_valid}, 32'd0);

    // Requester 1 flickers valid during requester 0's access
    bus.req_valid = 2'b01;
    #1;
    check("flk_ready0", {30'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 2'b10;
    bus.req_addr1 = 6'd9;
    #1;
    check("flk_no_ready", {30'd0, bus.req_ready}, 32'd0);
    tick();
    bus.req_valid = 2'b00;
    #1;
    check("flk_rsp0", {14'd0, bus.rsp_valid, bus.rsp_rdata}, {14'd0, 2'b01, 16'h1234});
    check("flk_ready_off", {30'd0, bus.req_ready}, 32'd0);
    tick();
    check("flk_no_rsp1", {29'd0, ram_load, bus.rsp_valid}, 32'd0);
    tick();
    check("flk_no_rsp1b", {30'd0, bus.rsp_valid}, 32'd0);

    // Tie with last_grant=0 -> requester 1 writes 0xBEEF to 63; clear_start in ACCESS ignored
    bus.req_valid  = 2'b11;
    bus.req_write  = 2'b10;
    bus.req_addr0  = 6'd63;
    bus.req_addr1  = 6'd63;
    bus.req_wdata1 = 16'hBEEF;
    #1;
    check("beef_grant", {30'd0, bus.req_ready}, 32'd2);
    tick();
    bus.req_valid = 2'b00;
    clear_start = 1'b1;
    #1;
    check("beef_access", {9'd0, ram_load, ram_address, ram_in}, {9'd0, 1'b1, 6'd63, 16'hBEEF});
    tick();
    clear_start = 1'b0;
    #1;
    check("beef_ack", {14'd0, bus.rsp_valid, bus.rsp_rdata}, {14'd0, 2'b10, 16'hBEEF});
    check("beef_clr_ignored", {30'd0, init_done, ram_load}, 32'd2);

    // clear_start in IDLE beats a pending read of 63
    clear_start     = 1'b1;
    bus.req_valid   = 2'b01;
    bus.req_write   = 2'b00;
    #1;
    check("clr_prio_ready", {30'd0, bus.req_ready}, 32'd0);
    tick();
    clear_start = 1'b0;
    #1;
    clear_check();
    check("clr_rd_ready", {30'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 2'b00;
    tick();
    check("clr_rd63", {14'd0, bus.rsp_valid, bus.rsp_rdata}, {14'd0, 2'b01, 16'h0000});

    // Reset during the ACCESS of a write to 7
    bus.req_valid  = 2'b01;
    bus.req_write  = 2'b01;
    bus.req_addr0  = 6'd7;
    bus.req_wdata0 = 16'h7777;
    #1;
    check("abort_ready", {30'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 2'b00;
    #1;
    check("abort_access", {25'd0, ram_load, ram_address}, {25'd0, 1'b1, 6'd7});
    reset = 1'b1;
    #1;
    check("abort_load", {31'd0, ram_load}, 32'd0);
    check("abort_state", {27'd0, init_done, bus.rsp_valid, bus.req_ready}, 32'd0);
    tick();
    check("abort_no_rsp", {14'd0, bus.rsp_valid, bus.rsp_rdata}, 32'd0);
    reset = 1'b0;
    #1;
    clear_check();
    bus.req_valid = 2'b01;
    bus.req_write = 2'b00;
    #1;
    check("abort_rd_ready", {30'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 2'b00;
    tick();
    check("abort_rd7", {14'd0, bus.rsp_valid, bus.rsp_rdata}, {14'd0, 2'b01, 16'h0000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester, round-robin arbiter and sequencer for a single-port 16-bit word RAM (the RAM64-class array: `in`/`load`/`address`/`out`, write at posedge, combinational read).
After reset, and on request, it clears the whole array to zero before serving traffic.
It grants one access at a time and returns read data or a write acknowledge through a one-cycle response pulse per requester.
It sits between CPU/DMA-style masters and the shared RAM instance.

Parameters:
AW, 6, RAM address width; depth = 2^AW words.
DW, 16, data word width.

Ports:
clock  in  1  system clock; all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
clear_start  in  1  request a full re-clear; sampled only in IDLE.
init_done  out  1  high when the array is cleared and the block is serving requests.
req_valid  in  2  per-requester command valid; held until ready.
req_write  in  2  per-requester 1=write, 0=read.
req_addr0, req_addr1  in  AW each  per-requester address.
req_wdata0, req_wdata1  in  DW each  per-requester write data.
req_ready  out  2  one-hot grant; the command transfers when valid & ready.
rsp_valid  out  2  one-cycle pulse to the requester whose access completed.
rsp_rdata  out  DW  read data (read) or written data (write); valid with rsp_valid.
ram_in  out  DW  to RAM `in`.
ram_load  out  1  to RAM `load`.
ram_address  out  AW  to RAM `address`.
ram_out  in  DW  from RAM `out`.

Behaviour:
- States: INIT, IDLE, ACCESS.
- Reset (asynchronous) sets:
  - state=INIT, clr_cnt=0, last_grant=1 (requester 0 wins the first tie).
  - init_done=0, rsp_valid=00, rsp_rdata=0, cmd regs=0.
  - While reset is high: ram_load=0 and req_ready=00, independent of state.
- INIT:
  - Each cycle drives ram_address=clr_cnt, ram_in=0, ram_load=1; clr_cnt increments.
  - When clr_cnt == 2^AW-1 the next state is IDLE and init_done rises in the same edge.
  - Duration is exactly 2^AW cycles; req_ready=00 throughout.
- IDLE:
  - ram_load=0.
  - If clear_start=1: goes to INIT (clr_cnt=0, init_done falls next edge). clear_start has priority over requests; no ready is issued that cycle.
  - Otherwise, if any req_valid is set, a winner is chosen combinationally:
    - Only one valid: that requester wins.
    - Both valid: the requester != last_grant wins.
  - req_ready[winner]=1 in that cycle only.
  - At the posedge: cmd_write/addr/wdata/id are latched from the winner, last_grant=winner, next state ACCESS.
- ACCESS:
  - ram_address=cmd_addr, ram_in=cmd_wdata, ram_load=cmd_write; req_ready=00.
  - At the posedge: rsp_rdata = cmd_write ? cmd_wdata : ram_out; rsp_valid[cmd_id]=1; next state IDLE.
- rsp_valid is a registered pulse, high for exactly the one cycle after ACCESS. It may coincide with the next grant.
- Throughput: one access per 2 cycles.
  - Read latency: 2 edges from the transfer edge to rsp_rdata valid.
- A requester dropping req_valid without ready is legal; nothing is latched.
- Addresses wrap naturally modulo 2^AW; no out-of-range case exists.
- Reset mid-ACCESS or mid-INIT aborts immediately, and any pending response is lost. After release the block restarts the full clear.
- clear_start asserted outside IDLE is ignored (not queued).

Decomposition:
- Shared package holds:
  - state encodings ST_INIT=2'd0, ST_IDLE=2'd1, ST_ACCESS=2'd2;
  - defaults AW_DEF=6, DW_DEF=16;
  - requester-index constants REQ0=0, REQ1=1.
- One sub-module is natural: rr_pick2. It is combinational; its inputs are valid[1:0] and last_grant, and its outputs are the one-hot grant and the winner index. The top level holds all registers.

Test Plan:
1. Reset release, AW=6 -> ram_load=1 for exactly 64 cycles, with ram_address 0..63 and ram_in=0. init_done rises at the edge after address 63 is written; req_ready stays 00 during the clear.
2. Requester 0 writes 0x1234 to address 5, then reads address 5 -> first response rsp_valid=01 with rsp_rdata=0x1234 (ack). Read response rsp_valid=01 with rsp_rdata=0x1234, arriving 2 edges after the transfer.
3. Both requesters hold valid continuously (reads of addresses 1 and 2) -> grants alternate 01, 10, 01, 10 in every IDLE cycle; requester 0 wins the first tie. Responses alternate accordingly.
4. Write 0xBEEF to address 63, pulse clear_start in IDLE, then read 63 after init_done returns -> init_done drops for 64 cycles and the read returns 0x0000. A clear_start pulse during ACCESS has no effect.
5. Assert reset during ACCESS of a write to address 7 -> ram_load=0 immediately and rsp_valid=00. After release a fresh 64-cycle clear runs, and a read of address 7 returns 0x0000.
6. Requester 1 asserts valid for one cycle, then drops it while requester 0 holds the grant -> no latch or response for requester 1; requester 0's response is unaffected.
